// File: rtl/dot_fp_seq.sv
// ---------------------------------------------------------------------------
// dot_fp_seq
//   Sequences a job of N k-element FP8 vector-pair beats through one
//   combinational dot_fp_spec unit. The per-beat dot products are summed
//   into a wide exact accumulator, and a sticky NaN flag is kept. The result
//   is presented on a valid/ready output.
//
//   Optional feature macro: DOT_FP_SEQ_ABORT_EN (adds i_abort; default off).
//
//   Ports:
//     clk, rst_n      clock, synchronous active-low reset
//     i_start         job start pulse (sampled only in IDLE)
//     i_num_blocks    beats in the job (saturated to max_blocks, 0 = empty job)
//     o_busy          high whenever the sequencer is not IDLE
//     i_valid/o_ready input beat handshake
//     i_vec_a/i_vec_b k FP8 operands per beat
//     o_valid/i_ready result handshake
//     o_acc           signed exact sum of per-beat dot products
//     o_nan           a NaN operand appeared in some beat of the job
//     i_abort         (DOT_FP_SEQ_ABORT_EN only) drop the running job
//
//   dot_fp_spec (also in this file) is the combinational k-element FP8 dot
//   product. Its output is an exact fixed-point value with LSB = (min
//   subnormal)^2. Products with a NaN operand contribute zero, and the NaN
//   is reported on o_nan.
// ---------------------------------------------------------------------------

module dot_fp_spec #(
    parameter  int exp_width = 4,
    parameter  int man_width = 3,
    parameter  int k         = 32,
    parameter  int e4m3_spec = 1,
    localparam int EW        = 1 + exp_width + man_width,
    localparam int OW        = 2 * ((1 << exp_width) + man_width) + $clog2(k)
) (
    input  logic [EW-1:0]        i_vec_a [k],
    input  logic [EW-1:0]        i_vec_b [k],
    output logic signed [OW-1:0] o_dp,
    output logic                 o_nan
);
    // Magnitude of one element in units of the minimum subnormal.
    localparam int MAGW = (1 << exp_width) + man_width;

    function automatic logic elem_nan(input logic [EW-1:0] x);
        logic [exp_width-1:0] e;
        logic [man_width-1:0] m;
        e = x[EW-2 -: exp_width];
        m = x[man_width-1:0];
        if (e4m3_spec != 0) return (&e) & (&m);
        else                return &e;
    endfunction

    function automatic logic [MAGW-1:0] elem_mag(input logic [EW-1:0] x);
        logic [exp_width-1:0] e;
        logic [MAGW-1:0]      sig;
        e   = x[EW-2 -: exp_width];
        sig = '0;
        sig[man_width-1:0] = x[man_width-1:0];
        // Normal numbers carry the hidden one and sit (e-1) binades above
        // the subnormal range.
        if (e != '0) begin
            sig[man_width] = 1'b1;
            sig = sig << (e - 1'b1);
        end
        return sig;
    endfunction

    function automatic logic signed [OW-1:0] elem_prod(input logic [EW-1:0] a,
                                                       input logic [EW-1:0] b);
        logic [OW-1:0] p;
        p = OW'(elem_mag(a)) * OW'(elem_mag(b));
        if (elem_nan(a) | elem_nan(b)) p = '0;
        else if (a[EW-1] ^ b[EW-1])    p = -p;
        return $signed(p);
    endfunction

    always_comb begin
        o_dp  = '0;
        o_nan = 1'b0;
        for (int i = 0; i < k; i++) begin
            o_dp  = o_dp + elem_prod(i_vec_a[i], i_vec_b[i]);
            o_nan = o_nan | elem_nan(i_vec_a[i]) | elem_nan(i_vec_b[i]);
        end
    end
endmodule

module dot_fp_seq #(
    parameter  int exp_width  = 4,
    parameter  int man_width  = 3,
    parameter  int k          = 32,
    parameter  int e4m3_spec  = 1,
    parameter  int max_blocks = 64,
    localparam int EW         = 1 + exp_width + man_width,
    localparam int OW         = 2 * ((1 << exp_width) + man_width) + $clog2(k),
    localparam int AW         = OW + $clog2(max_blocks),
    localparam int CW         = $clog2(max_blocks + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_start,
    input  logic [CW-1:0]        i_num_blocks,
    output logic                 o_busy,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [EW-1:0]        i_vec_a [k],
    input  logic [EW-1:0]        i_vec_b [k],
    output logic                 o_valid,
    input  logic                 i_ready,
`ifdef DOT_FP_SEQ_ABORT_EN
    input  logic                 i_abort,
`endif
    output logic signed [AW-1:0] o_acc,
    output logic                 o_nan
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [CW-1:0]         r_num, r_cnt;
    logic signed [AW-1:0]  r_acc;
    logic                  r_nan;
    logic                  r_vld_p1;
    logic signed [OW-1:0]  r_dp_p1;
    logic                  r_nan_p1;

    logic signed [OW-1:0]  w_dp;
    logic                  w_dp_nan;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_abort;

    function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] n);
        if (n > CW'(max_blocks)) return CW'(max_blocks);
        return n;
    endfunction

    dot_fp_spec #(
        .exp_width (exp_width),
        .man_width (man_width),
        .k         (k),
        .e4m3_spec (e4m3_spec)
    ) u_dot (
        .i_vec_a (i_vec_a),
        .i_vec_b (i_vec_b),
        .o_dp    (w_dp),
        .o_nan   (w_dp_nan)
    );

`ifdef DOT_FP_SEQ_ABORT_EN
    assign w_abort = i_abort && (r_state == RUN || r_state == FLUSH);
`else
    assign w_abort = 1'b0;
`endif

    // o_ready and o_valid depend on state only, so there is no combinational
    // path from i_valid or i_ready.
    assign w_hs   = i_valid && o_ready;
    assign w_last = (r_cnt == r_num - 1'b1);
    assign o_acc  = r_acc;
    assign o_nan  = r_nan;

    always_comb begin
        w_state_nxt = r_state;
        o_ready     = 1'b0;
        o_valid     = 1'b0;
        o_busy      = (r_state != IDLE);
        case (r_state)
            IDLE: begin
                if (i_start) w_state_nxt = (i_num_blocks == '0) ? DONE : RUN;
            end
            RUN: begin
                o_ready = 1'b1;
                if (w_hs && w_last) w_state_nxt = FLUSH;
            end
            FLUSH: begin
                w_state_nxt = DONE;
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_vld_p1 <= 1'b0;
            r_num    <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_nan    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            // An aborted cycle's beat never reaches the accumulator.
            r_vld_p1 <= w_hs && !w_abort;
            if (r_state == IDLE && i_start) begin
                r_num <= sat_count(i_num_blocks);
                r_cnt <= '0;
                r_acc <= '0;
                r_nan <= 1'b0;
            end else begin
                if (w_hs) r_cnt <= r_cnt + 1'b1;
                if (w_abort) begin
                    r_acc <= '0;
                    r_nan <= 1'b0;
                end else if (r_vld_p1) begin
                    r_acc <= r_acc + $signed({{(AW-OW){r_dp_p1[OW-1]}}, r_dp_p1});
                    r_nan <= r_nan | r_nan_p1;
                end
            end
        end
    end

    // ---- stage P1: registered dot_fp_spec result of the accepted beat ----
    always_ff @(posedge clk) begin
        if (w_hs) begin
            r_dp_p1  <= w_dp;
            r_nan_p1 <= w_dp_nan;
        end
    end
endmodule
